// File: rtl/mem_access_unit.sv
// MEM-stage bus initiator: issues one req/ready transaction per load/store,
// stalls the pipeline until it completes, and formats load results for MEM/WB.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        bus_error
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count, count_next;

    logic               bus_req_next, bus_we_next;
    logic [31:0]        bus_addr_next, bus_wdata_next;
    logic [3:0]         bus_be_next;
    logic [31:0]        load_data_next;
    logic               load_valid_next, bus_error_next;

    // Access attributes captured at issue; the EX/MEM inputs are not trusted after IDLE.
    logic [1:0]         lat_size, lat_size_next;
    logic [1:0]         lat_lane, lat_lane_next;
    logic               lat_unsigned, lat_unsigned_next;
    logic               lat_read, lat_read_next;

    logic               op;
    logic               is_misaligned;
    logic [3:0]         be_calc;
    logic [31:0]        wdata_calc;

    function automatic logic [31:0] format_load(input logic [31:0] d, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic uns);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [7:0]  byte_v;
        shifted = d >> {lane, 3'b000};
        byte_v  = shifted[7:0];
        half    = lane[1] ? d[31:16] : d[15:0];
        if (sz[1])
            return d;
        else if (sz[0])
            return uns ? {16'h0000, half} : {{16{half[15]}}, half};
        else
            return uns ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
    endfunction

    assign op            = mem_read ^ mem_write;
    assign is_misaligned = (size == 2'b01 && address[0]) || (size[1] && address[1:0] != 2'b00);

    // Byte enables and lane-replicated store data for the current request.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = write_data;
        if (!size[1]) begin
            if (size[0]) begin
                be_calc    = address[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{write_data[15:0]}};
            end else begin
                be_calc    = 4'b0001 << address[1:0];
                wdata_calc = {4{write_data[7:0]}};
            end
        end
    end

    always_comb begin
        state_next        = state;
        count_next        = count;
        bus_req_next      = bus_req;
        bus_we_next       = bus_we;
        bus_addr_next     = bus_addr;
        bus_wdata_next    = bus_wdata;
        bus_be_next       = bus_be;
        load_data_next    = load_data;
        load_valid_next   = 1'b0;
        bus_error_next    = 1'b0;
        lat_size_next     = lat_size;
        lat_lane_next     = lat_lane;
        lat_unsigned_next = lat_unsigned;
        lat_read_next     = lat_read;
        stall             = 1'b0;
        misaligned        = 1'b0;

        case (state)
            IDLE: begin
                if (op) begin
                    if (is_misaligned) begin
                        misaligned = 1'b1;
                    end else begin
                        stall             = 1'b1;
                        state_next        = REQ;
                        count_next        = '0;
                        bus_req_next      = 1'b1;
                        bus_we_next       = mem_write;
                        bus_addr_next     = {address[31:2], 2'b00};
                        bus_wdata_next    = wdata_calc;
                        bus_be_next       = be_calc;
                        lat_size_next     = size;
                        lat_lane_next     = address[1:0];
                        lat_unsigned_next = unsigned_ld;
                        lat_read_next     = mem_read;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (bus_ready) begin
                    bus_req_next = 1'b0;
                    state_next   = DONE;
                    if (lat_read) begin
                        load_data_next  = format_load(bus_rdata, lat_size, lat_lane, lat_unsigned);
                        load_valid_next = 1'b1;
                    end
                end else if (count == CNT_W'(TIMEOUT - 1)) begin
                    bus_req_next   = 1'b0;
                    bus_error_next = 1'b1;
                    state_next     = DONE;
                    if (lat_read)
                        load_data_next = '0;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_be       <= '0;
            load_data    <= '0;
            load_valid   <= 1'b0;
            bus_error    <= 1'b0;
            lat_size     <= '0;
            lat_lane     <= '0;
            lat_unsigned <= 1'b0;
            lat_read     <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            bus_req      <= bus_req_next;
            bus_we       <= bus_we_next;
            bus_addr     <= bus_addr_next;
            bus_wdata    <= bus_wdata_next;
            bus_be       <= bus_be_next;
            load_data    <= load_data_next;
            load_valid   <= load_valid_next;
            bus_error    <= bus_error_next;
            lat_size     <= lat_size_next;
            lat_lane     <= lat_lane_next;
            lat_unsigned <= lat_unsigned_next;
            lat_read     <= lat_read_next;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, signed/unsigned loads,
// misalignment, bus timeout and reset mid-transaction.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] address, write_data;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, misaligned, bus_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    logic        unstable;
    int          req_cyc, stall_cyc;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .size(size),
        .unsigned_ld(unsigned_ld), .address(address), .write_data(write_data),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .misaligned(misaligned), .bus_error(bus_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns;
        address = addr; write_data = wd;
    endtask

    // Runs an issued access from IDLE to DONE; bus_ready on the ready_at-th REQ cycle (0 = never).
    task automatic run_access(input int ready_at, input logic [31:0] rdata);
        bit done;
        done = 0; req_cyc = 0; stall_cyc = 0; unstable = 1'b0;
        #1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (stall) stall_cyc++;
            if (bus_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
                end else if (bus_addr !== cap_addr || bus_wdata !== cap_wdata ||
                             bus_be !== cap_be || bus_we !== cap_we) begin
                    unstable = 1'b1;
                end
                bus_ready = (req_cyc == ready_at);
                bus_rdata = rdata;
            end else begin
                bus_ready = 1'b0;
            end
            tick();
            if (!bus_req && req_cyc > 0) done = 1;
        end
        bus_ready = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        if (!done) check("access_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b1; bus_ready = 1'b0; bus_rdata = '0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        tick(); tick();
        reset = 1'b0;
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_addr", bus_addr, 32'h0);
        check("rst_ld", load_data, 32'h0);
        check("rst_lv", 32'(load_valid), 32'd0);
        check("rst_err", 32'(bus_error), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // sw 0xDEADBEEF @0x8, ready on third REQ cycle
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF);
        run_access(3, 32'h0);
        check("sw_req_cyc", 32'(req_cyc), 32'd3);
        check("sw_stall_cyc", 32'(stall_cyc), 32'd4);
        check("sw_addr", cap_addr, 32'h8);
        check("sw_be", 32'(cap_be), 32'hF);
        check("sw_wdata", cap_wdata, 32'hDEADBEEF);
        check("sw_we", 32'(cap_we), 32'd1);
        check("sw_stable", 32'(unstable), 32'd0);
        check("sw_done_stall", 32'(stall), 32'd0);
        check("sw_done_lv", 32'(load_valid), 32'd0);
        tick();

        // lb @0x13 -> lane 3 = 0x80, sign-extended
        drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        run_access(1, 32'h80FF_7F01);
        check("lb_req_cyc", 32'(req_cyc), 32'd1);
        check("lb_stall_cyc", 32'(stall_cyc), 32'd2);
        check("lb_addr", cap_addr, 32'h10);
        check("lb_be", 32'(cap_be), 32'h8);
        check("lb_we", 32'(cap_we), 32'd0);
        check("lb_data", load_data, 32'hFFFF_FF80);
        check("lb_lv", 32'(load_valid), 32'd1);
        tick();
        check("lb_lv_clr", 32'(load_valid), 32'd0);
        check("lb_hold", load_data, 32'hFFFF_FF80);

        // lbu same access
        drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        run_access(1, 32'h80FF_7F01);
        check("lbu_data", load_data, 32'h0000_0080);
        check("lbu_lv", 32'(load_valid), 32'd1);
        tick();

        // sh 0x1234 @0x6
        drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_1234);
        run_access(2, 32'h0);
        check("sh_addr", cap_addr, 32'h4);
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wdata, 32'h1234_1234);
        check("sh_ld_kept", load_data, 32'h0000_0080);
        tick();

        // lh @0x6 -> upper half 0x8001, sign-extended
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
        run_access(1, 32'h8001_0000);
        check("lh_data", load_data, 32'hFFFF_8001);
        check("lh_be", 32'(cap_be), 32'hC);
        tick();

        // lh @0x5 is misaligned: no stall, no bus activity
        drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h5, 32'h0);
        #1;
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_stall", 32'(stall), 32'd0);
        tick();
        check("mis_req1", 32'(bus_req), 32'd0);
        tick();
        check("mis_req2", 32'(bus_req), 32'd0);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        #1;
        check("mis_clr", 32'(misaligned), 32'd0);
        tick();

        // lw @0x10 with no bus_ready -> timeout after 16 REQ cycles
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        run_access(0, 32'h0);
        check("to_req_cyc", 32'(req_cyc), 32'd16);
        check("to_err", 32'(bus_error), 32'd1);
        check("to_ld", load_data, 32'h0);
        check("to_stall", 32'(stall), 32'd0);
        tick();
        check("to_err_clr", 32'(bus_error), 32'd0);
        check("to_idle_stall", 32'(stall), 32'd0);

        // lw @0x20 interrupted by reset while in REQ, then a late bus_ready
        drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        #1;
        check("rr_issue_stall", 32'(stall), 32'd1);
        tick();
        check("rr_req", 32'(bus_req), 32'd1);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_req_drop", 32'(bus_req), 32'd0);
        check("rr_stall", 32'(stall), 32'd0);
        bus_ready = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        bus_ready = 1'b0;
        check("rr_late_lv", 32'(load_valid), 32'd0);
        check("rr_late_ld", load_data, 32'h0);
        check("rr_late_req", 32'(bus_req), 32'd0);
        tick();
        check("rr_late_lv2", 32'(load_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
